// File: rtl/step_phase_sequencer_pkg.sv
// step_phase_sequencer_pkg: shared FSM states, coil phase table and index stepping helper
package step_phase_sequencer_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] PHASE_TABLE [0:7] = '{
      4'b1000, 4'b1100, 4'b0100, 4'b0110,
      4'b0010, 4'b0011, 4'b0001, 4'b1001
   };

   // Full step moves two entries from an even index, or one entry to re-align from an odd index
   function automatic logic [2:0] next_index(input logic [2:0] idx, input logic fwd, input logic half);
      logic [2:0] w_d;
      w_d = (half || idx[0]) ? 3'd1 : 3'd2;
      return fwd ? idx + w_d : idx - w_d;
   endfunction

endpackage

// File: rtl/step_phase_sequencer_edge_sync_rise.sv
// edge_sync_rise: multi-stage synchroniser for an asynchronous clock-like input with a one-cycle rise pulse
module edge_sync_rise #(
   parameter int STAGES = 2
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic i_async,
   output logic o_rise
);

   logic [STAGES-1:0] r_sync;
   logic              r_hist;

   // Shift the async input through the chain and keep one history flop for edge detection
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_async};
         r_hist <= r_sync[STAGES-1];
      end
   end

   assign o_rise = r_sync[STAGES-1] & ~r_hist;

endmodule

// File: rtl/step_phase_sequencer.sv
// step_phase_sequencer: stepper coil phase sequencer with step counting and busy/done handshake (STEP_HOLD_EN keeps the last pattern energised in IDLE)
module step_phase_sequencer
   import step_phase_sequencer_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             step_clk,
   input  logic             enable,
   input  logic             dir,
   input  logic             half_step,
   input  logic             start,
   input  logic [CNT_W-1:0] step_target,
   output logic             busy,
   output logic             done,
   output logic [3:0]       phase_out,
   output logic [CNT_W-1:0] step_count
);

   state_t           r_state, w_state_nxt;
   logic [2:0]       r_index, w_index_nxt;
   logic [CNT_W-1:0] r_count, w_count_nxt;
   logic [CNT_W-1:0] r_target, w_target_nxt;
   logic             w_rise;
   logic             w_show;

   edge_sync_rise #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .i_async (step_clk),
      .o_rise  (w_rise)
   );

   // Register FSM state, phase index, step counter and latched target
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_index  <= 3'd0;
         r_count  <= '0;
         r_target <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_index  <= w_index_nxt;
         r_count  <= w_count_nxt;
         r_target <= w_target_nxt;
      end
   end

   // Accept moves in IDLE, advance on enabled rises in RUN, pulse done for one cycle
   always_comb begin
      w_state_nxt  = r_state;
      w_index_nxt  = r_index;
      w_count_nxt  = r_count;
      w_target_nxt = r_target;
      case (r_state)
         ST_IDLE: if (start) begin
            w_target_nxt = step_target;
            w_count_nxt  = '0;
            w_state_nxt  = (step_target == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: if (w_rise && enable) begin
            w_index_nxt = next_index(r_index, dir, half_step);
            w_count_nxt = r_count + CNT_W'(1);
            if (w_count_nxt == r_target) w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

`ifdef STEP_HOLD_EN
   logic r_held;

   // Once a move has finished, IDLE keeps holding torque at the last position
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) r_held <= 1'b0;
      else if (r_state == ST_DONE) r_held <= 1'b1;
   end

   assign w_show = (r_state != ST_IDLE) || r_held;
`else
   assign w_show = (r_state != ST_IDLE);
`endif

   assign busy       = (r_state == ST_RUN);
   assign done       = (r_state == ST_DONE);
   assign step_count = r_count;
   assign phase_out  = (enable && w_show) ? PHASE_TABLE[r_index] : 4'b0000;

endmodule

// File: tb/tb_step_phase_sequencer.sv
// tb_step_phase_sequencer: directed bench with a cycle model of the stepper sequencer (honours STEP_HOLD_EN)
module tb_step_phase_sequencer;

   logic        clk_in = 1'b0;
   logic        rst_n = 1'b0;
   logic        step_clk = 1'b0;
   logic        enable = 1'b0;
   logic        dir = 1'b0;
   logic        half_step = 1'b0;
   logic        start = 1'b0;
   logic [15:0] step_target = '0;
   logic        busy, done;
   logic [3:0]  phase_out;
   logic [15:0] step_count;

   int checks = 0;
   int failures = 0;

   step_phase_sequencer #(.CNT_W(16), .SYNC_STAGES(2)) dut (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .step_clk    (step_clk),
      .enable      (enable),
      .dir         (dir),
      .half_step   (half_step),
      .start       (start),
      .step_target (step_target),
      .busy        (busy),
      .done        (done),
      .phase_out   (phase_out),
      .step_count  (step_count)
   );

   always #5 clk_in = ~clk_in;

   logic [3:0] tbl [0:7] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                             4'b0010, 4'b0011, 4'b0001, 4'b1001};

   // Model: a step lands on the edge where step_clk was seen high two edges ago but low three edges ago
   int       m_idx = 0, m_steps = 0, m_goal = 0, m_d;
   bit       m_run = 0, m_fin = 0, m_held = 0, m_rise;
   bit [2:0] m_seen = '0;

   always @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         m_idx = 0; m_steps = 0; m_goal = 0;
         m_run = 0; m_fin = 0; m_held = 0; m_seen = '0;
      end else begin
         m_rise = m_seen[1] && !m_seen[2];
         m_seen = {m_seen[1:0], step_clk};
         if (m_fin) begin
            m_fin = 0;
            m_held = 1;
         end else if (m_run) begin
            if (m_rise && enable) begin
               m_d = (half_step || (m_idx % 2 == 1)) ? 1 : 2;
               m_idx = (m_idx + (dir ? m_d : 8 - m_d)) % 8;
               m_steps++;
               if (m_steps == m_goal) begin
                  m_run = 0;
                  m_fin = 1;
               end
            end
         end else if (start) begin
            m_goal = int'(step_target);
            m_steps = 0;
            if (m_goal == 0) m_fin = 1;
            else m_run = 1;
         end
      end
   end

   function automatic logic [3:0] exp_phase();
      if (!enable) return 4'b0000;
      if (m_run || m_fin) return tbl[m_idx];
`ifdef STEP_HOLD_EN
      return m_held ? tbl[m_idx] : 4'b0000;
`else
      return 4'b0000;
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk_in) begin
      chk("cmp_busy", 32'(busy), 32'(m_run));
      chk("cmp_done", 32'(done), 32'(m_fin));
      chk("cmp_count", 32'(step_count), 32'(m_steps));
      chk("cmp_phase", 32'(phase_out), 32'(exp_phase()));
   end

   task automatic tick();
      @(posedge clk_in);
      #2;
   endtask

   task automatic go(input logic [15:0] tgt);
      step_target = tgt;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse(input string nm, input logic [3:0] exp_ph, input logic exp_dn);
      step_clk = 1'b1;
      tick();
      tick();
      step_clk = 1'b0;
      tick();
      chk({nm, "_phase"}, 32'(phase_out), 32'(exp_ph));
      chk({nm, "_done"}, 32'(done), 32'(exp_dn));
      tick();
      tick();
   endtask

   logic [3:0] hold_exp;

   initial begin
      logic [3:0] s1 [0:4] = '{4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011};
      logic [3:0] s5 [0:3] = '{4'b0011, 4'b0001, 4'b1001, 4'b1000};
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_phase", 32'(phase_out), 0);
      chk("rst_count", 32'(step_count), 0);
      rst_n = 1'b1;
      tick();
      enable = 1'b1; dir = 1'b1; half_step = 1'b1;
      go(16'd5);
      chk("s1_busy", 32'(busy), 1);
      for (int i = 0; i < 5; i++) pulse($sformatf("s1_%0d", i), s1[i], i == 4);
      chk("s1_count", 32'(step_count), 5);
      chk("s1_busy_after", 32'(busy), 0);
      chk("model_idx", 32'(m_idx), 5);
`ifdef STEP_HOLD_EN
      hold_exp = 4'b0011;
`else
      hold_exp = 4'b0000;
`endif
      pulse("s1_extra", hold_exp, 1'b0);
      chk("s1_count_hold", 32'(step_count), 5);
      go(16'd10);
      pulse("rst_mv_0", 4'b0001, 1'b0);
      pulse("rst_mv_1", 4'b1001, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("async_busy", 32'(busy), 0);
      chk("async_done", 32'(done), 0);
      chk("async_phase", 32'(phase_out), 0);
      chk("async_count", 32'(step_count), 0);
      tick();
      rst_n = 1'b1;
      tick();
      dir = 1'b0; half_step = 1'b0;
      go(16'd3);
      pulse("rev_0", 4'b0001, 1'b0);
      pulse("rev_1", 4'b0010, 1'b0);
      pulse("rev_2", 4'b0100, 1'b1);
      half_step = 1'b1;
      go(16'd1);
      pulse("odd_set", 4'b1100, 1'b1);
      half_step = 1'b0; dir = 1'b1;
      go(16'd2);
      pulse("realign_0", 4'b0100, 1'b0);
      pulse("realign_1", 4'b0010, 1'b1);
      go(16'd0);
      chk("zero_done", 32'(done), 1);
      chk("zero_busy", 32'(busy), 0);
      chk("zero_count", 32'(step_count), 0);
      tick();
      chk("zero_done_end", 32'(done), 0);
      half_step = 1'b1;
      go(16'd4);
      enable = 1'b0;
      tick();
      chk("en_off_phase", 32'(phase_out), 0);
      pulse("en_off_0", 4'b0000, 1'b0);
      pulse("en_off_1", 4'b0000, 1'b0);
      chk("en_off_count", 32'(step_count), 0);
      enable = 1'b1;
      for (int i = 0; i < 4; i++) pulse($sformatf("en_on_%0d", i), s5[i], i == 3);
      chk("en_on_count", 32'(step_count), 4);
      step_target = 16'd3;
      start = 1'b1;
      tick();
      step_clk = 1'b1;
      tick();
      chk("lat_edge1", 32'(step_count), 0);
      tick();
      chk("lat_edge2", 32'(step_count), 0);
      step_clk = 1'b0;
      tick();
      chk("lat_edge3", 32'(step_count), 1);
      chk("lat_phase", 32'(phase_out), 32'(4'b1100));
      chk("start_in_run", 32'(busy), 1);
      tick();
      tick();
      pulse("start_held", 4'b0100, 1'b0);
      chk("start_held_count", 32'(step_count), 2);
      start = 1'b0;
      pulse("lat_last", 4'b0110, 1'b1);
      tick();
`ifdef STEP_HOLD_EN
      hold_exp = 4'b0110;
`else
      hold_exp = 4'b0000;
`endif
      chk("idle_hold", 32'(phase_out), 32'(hold_exp));
      chk("idle_count", 32'(step_count), 3);
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
